// File: rtl/seg7_capture_if.sv
// Display-port signal bundle: scanner-side lines in, decoded frame out.
interface seg7_capture_if #(
    parameter int NUM_DIGITS = 8
);
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic [NUM_DIGITS-1:0]   code_err;
    logic                    frame_done;
    logic                    timeout;

    modport master (
        output seg_n, an_n,
        input  value, digit_valid, code_err, frame_done, timeout
    );

    modport slave (
        input  seg_n, an_n,
        output value, digit_valid, code_err, frame_done, timeout
    );
endinterface

// File: rtl/seg7_capture.sv
// Seven-segment read-back monitor: debounces each selected digit, decodes it,
// and publishes a whole multi-digit frame atomically.
module seg7_capture #(
    parameter int NUM_DIGITS     = 8,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input logic           clk,
    input logic           resetn,
    seg7_capture_if.slave bus
);
    localparam int SW = NUM_DIGITS + 7;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {SETTLE, CAPTURED} state_t;

    state_t                  state, state_next;
    logic [SW-1:0]           s1, s2;
    logic [7:0]              cnt, cnt_next;
    logic                    stable, fire, capture, sel_ok, publish;
    logic [NUM_DIGITS-1:0]   sel_hot;
    logic [IW-1:0]           sel_idx;
    logic [3:0]              dec_nib;
    logic                    dec_valid, dec_err;
    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_valid, shadow_err, seen, seen_next;
    logic [TW-1:0]           tcnt;

    assign stable  = (s1 == s2);
    assign sel_hot = ~s1[SW-1:7];
    assign sel_ok  = (sel_hot != '0) && ((sel_hot & (sel_hot - 1'b1)) == '0);
    assign publish = &seen;

    always_comb begin
        sel_idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (sel_hot[i]) sel_idx = IW'(i);
        end
    end

    always_comb begin
        dec_nib   = 4'h0;
        dec_valid = 1'b1;
        dec_err   = 1'b0;
        case (s1[6:0])
            7'b0000001: dec_nib = 4'h0;
            7'b1001111: dec_nib = 4'h1;
            7'b0010010: dec_nib = 4'h2;
            7'b0000110: dec_nib = 4'h3;
            7'b1001100: dec_nib = 4'h4;
            7'b0100100: dec_nib = 4'h5;
            7'b0100000: dec_nib = 4'h6;
            7'b0001111: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0000100: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b1100000: dec_nib = 4'hB;
            7'b0110001: dec_nib = 4'hC;
            7'b1000010: dec_nib = 4'hD;
            7'b0110000: dec_nib = 4'hE;
            7'b0111000: dec_nib = 4'hF;
            7'b1111111: dec_valid = 1'b0;
            default: begin
                dec_valid = 1'b0;
                dec_err   = 1'b1;
            end
        endcase
    end

    // Capture fires on the edge where the counter would reach the threshold.
    always_comb begin
        cnt_next   = cnt;
        state_next = state;
        if (!stable) begin
            cnt_next = '0;
        end else if (cnt != 8'(STABLE_CYCLES)) begin
            cnt_next = cnt + 8'd1;
        end
        fire = (state == SETTLE) && stable && (cnt_next == 8'(STABLE_CYCLES));
        if (!stable) begin
            state_next = SETTLE;
        end else if (fire) begin
            state_next = CAPTURED;
        end
        capture = fire && sel_ok;
    end

    // Publish clears the mask first so a simultaneous capture starts the next frame.
    always_comb begin
        seen_next = publish ? '0 : seen;
        if (capture) seen_next[sel_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1    <= '1;
            s2    <= '1;
            cnt   <= '0;
            state <= SETTLE;
        end else begin
            s1    <= {bus.an_n, bus.seg_n};
            s2    <= s1;
            cnt   <= cnt_next;
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            seen         <= '0;
            shadow_value <= '0;
            shadow_valid <= '0;
            shadow_err   <= '0;
        end else begin
            seen <= seen_next;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (capture && (sel_idx == IW'(i))) begin
                    shadow_value[4*i +: 4] <= dec_nib;
                    shadow_valid[i]        <= dec_valid;
                    shadow_err[i]          <= dec_err;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.value       <= '0;
            bus.digit_valid <= '0;
            bus.code_err    <= '0;
            bus.frame_done  <= 1'b0;
        end else begin
            bus.frame_done <= publish;
            if (publish) begin
                bus.value       <= shadow_value;
                bus.digit_valid <= shadow_valid;
                bus.code_err    <= shadow_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tcnt        <= '0;
            bus.timeout <= 1'b0;
        end else if (capture) begin
            tcnt        <= '0;
            bus.timeout <= 1'b0;
        end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TW'(TIMEOUT_CYCLES - 1)) bus.timeout <= 1'b1;
        end
    end
endmodule

// File: doc/seg7_capture.md
# seg7_capture

Read-back monitor for the multiplexed seven-segment display port. It watches the active-low segment and digit-select lines driven by the display scanner. For each selected digit it waits for the pattern to settle, decodes it back to a hex nibble, and assembles a complete multi-digit word. Completed words are published atomically, so the func-test harness and on-board debug logic can compare what the display shows against the expected value.

## Interface
Parameters:
- NUM_DIGITS, 8: number of multiplexed digits; sets the width of an_n and of every per-digit output.
- STABLE_CYCLES, 16: consecutive matching samples required before a digit is accepted. Legal range 1..255.
- TIMEOUT_CYCLES, 65536: cycles without any capture before timeout asserts. Must be at least 2.

Ports:
- clk  in  1  system clock; inputs are synchronous to clk.
- resetn  in  1  reset; one clock, reset is synchronous and active-low.
- seg_n  in  7  segment lines, active-low; bit6=a, bit5=b, … bit0=g.
- an_n  in  NUM_DIGITS  digit select, active-low; exactly one low bit selects a digit index.
- value  out  4*NUM_DIGITS  decoded word; digit i occupies bits [4i+3:4i].
- digit_valid  out  NUM_DIGITS  1 = digit i decoded to a legal hex glyph.
- code_err  out  NUM_DIGITS  1 = digit i showed a pattern that is neither a legal glyph nor blank.
- frame_done  out  1  one-cycle pulse when value, digit_valid and code_err update.
- timeout  out  1  sticky flag meaning no capture for TIMEOUT_CYCLES cycles.

## Operation
- Input stage: two registers. s1 samples {an_n, seg_n} every cycle, and s2 takes s1. Both reset to all ones.
- Stability counter cnt, 8 bits:
  - When s1==s2, cnt increments, saturating at STABLE_CYCLES.
  - Otherwise cnt is cleared to 0 and the FSM enters SETTLE.
- FSM states:
  - SETTLE to CAPTURED when cnt reaches STABLE_CYCLES. The capture action below fires on that same edge.
  - CAPTURED to SETTLE on any s1/s2 mismatch.
  - CAPTURED holds while the inputs are stable. Exactly one capture occurs per stable window.
- Capture action: only when an_n in s1 has exactly one zero bit, at index i.
  - Zero or multiple low bits: no capture and no seen update, but the FSM still moves to CAPTURED.
- Decode of seg_n, written into shadow slot i:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7.
  - 0000000→8, 0000100→9, 0001000→A, 1100000→b, 0110001→C, 1000010→d, 0110000→E, 0111000→F.
  - Legal glyph: nibble = code, valid=1, err=0.
  - Blank 1111111: nibble=0, valid=0, err=0.
  - Any other pattern: nibble=0, valid=0, err=1.
- seen mask: bit i is set on capture of digit i. Re-capturing a digit already seen in the current frame overwrites its shadow slot.
- Frame publish: on the cycle after seen becomes all ones:
  - Copy the shadow slots to value, digit_valid and code_err.
  - Pulse frame_done for one cycle and clear seen.
- Outputs change only at frame publish or reset; partial frames are never visible.
- Timeout: a counter increments every cycle without a capture and is cleared on any capture.
  - When it reaches TIMEOUT_CYCLES, timeout is set and the counter saturates.
  - timeout clears on the next capture.

## Timing
- Reset values: value=0, digit_valid=0, code_err=0, frame_done=0, timeout=0.
  - Internally: seen=0, cnt=0, FSM=SETTLE, timeout counter=0, shadow slots=0.
- Capture latency: let E0 be the edge where the new pattern is first sampled into s1.
  - The slot is written at edge E0+STABLE_CYCLES+1.
  - The input must be held from E0 through E0+STABLE_CYCLES; a shorter pulse is never captured.
- Publish latency: frame_done rises one cycle after the edge that captures the last unseen digit.
- Capture and timeout threshold on the same cycle: capture wins. The counter clears and timeout stays 0 (or clears).
- Publish and a new capture on the same cycle: seen is cleared and then the new digit's bit is set, so the new capture counts toward the next frame.
- resetn low mid-frame: all state returns to reset values on that edge and the partial frame is discarded.

## Test plan
- Scan 0x1234ABCD: each digit held for 20 cycles, STABLE_CYCLES=16. Required: one frame_done, value=32'h1234ABCD, digit_valid=8'hFF, code_err=0.
- Glitch: digit 0 shows 0010010 for 10 cycles, then 0000001 for 20 cycles. Required: slot 0 = 0 and no code_err; a full scan then publishes nibble 0 at digit 0.
- Blank and illegal patterns: digit 7 = 1111111, digit 6 = 1010101, others legal. Required: digit_valid bit7=0 and bit6=0, code_err=8'h40.
- an_n=all ones, or two bits low, held for 100 cycles. Required: no capture, seen unchanged, outputs unchanged.
- Inputs frozen for TIMEOUT_CYCLES cycles. Required: timeout=1 exactly TIMEOUT_CYCLES cycles after the last capture; the next capture clears it.
- resetn pulsed low after 5 digits are captured. Required: all outputs 0; a following full scan gives exactly one frame_done containing only post-reset data.
